ebi_master: RTL and testbench
=============================

EBI_MASTER -- requirements
Module: ebi_master

Interface
REQ-001 SHALL have parameter T_SETUP, default 1, meaning cycles with cs_n low before the strobe (legal 1..15).
REQ-002 SHALL have parameter T_STROBE, default 2, meaning cycles with the oe_n/we_n strobe low (legal 1..15).
REQ-003 SHALL have parameter T_HOLD, default 1, meaning cycles with cs_n low after the strobe rises (legal 1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port req  input  1  host transaction request, sampled only in IDLE.
REQ-007 SHALL have port wr  input  1  host direction: 1 = write, 0 = read.
REQ-008 SHALL have port addr  input  6  host word address.
REQ-009 SHALL have port wdata  input  32  host write data.
REQ-010 SHALL have port be  input  4  host byte enables, active-high.
REQ-011 SHALL have port rdata  output  32  read data captured from the bus.
REQ-012 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port cs_n  output  1  bus chip select, active-low.
REQ-015 SHALL have port oe_n  output  1  bus output enable (read strobe), active-low.
REQ-016 SHALL have port we_n  output  4  bus per-byte write strobes, active-low.
REQ-017 SHALL have port rd_wr  output  1  bus direction: 1 = read, 0 = write.
REQ-018 SHALL have port ebi_addr  output  8  bus byte address, equal to {latched addr, 2'b00}.
REQ-019 SHALL have port data_o  output  32  bus write data.
REQ-020 SHALL have port data_oe  output  1  bus data tri-state enable, high only during write transactions.
REQ-021 SHALL have port data_i  input  32  bus read data.

Function
REQ-022 SHALL implement states IDLE, SETUP, STROBE and HOLD, with one 4-bit down-counter shared by the timed states.
REQ-023 SHALL, in IDLE with req=1, latch wr, addr, wdata and be, and enter SETUP on the next edge; req=0 SHALL leave the block in IDLE.
REQ-024 SHALL ignore req in all states other than IDLE; no queueing.
REQ-025 SHALL, in IDLE, drive cs_n=1, oe_n=1, we_n=4'b1111, rd_wr=1 and data_oe=0, and hold ebi_addr and data_o at their last latched values.
REQ-026 SHALL, in SETUP, drive cs_n=0, rd_wr=~wr_latched, data_oe=wr_latched, keep both strobes high, and stay T_SETUP cycles before entering STROBE.
REQ-027 SHALL, in STROBE on a read, drive oe_n=0, and on a write drive we_n=~be_latched; it SHALL stay T_STROBE cycles before entering HOLD.
REQ-028 SHALL, on a read, load rdata from data_i at the clock edge that ends the last STROBE cycle; rdata SHALL otherwise hold its value, including across writes.
REQ-029 SHALL, in HOLD, raise both strobes while keeping cs_n, rd_wr, ebi_addr, data_o and data_oe unchanged, and stay T_HOLD cycles before entering IDLE.
REQ-030 SHALL assert ack for exactly the first IDLE cycle after HOLD.
REQ-031 SHALL give a req-to-ack latency of exactly 1+T_SETUP+T_STROBE+T_HOLD cycles.
REQ-032 SHALL accept a req present in the ack cycle, so back-to-back transactions have exactly one cycle with cs_n=1 between them.
REQ-033 SHALL complete a write with be=4'b0000 with full timing and ack while keeping we_n=4'b1111 throughout.
REQ-034 SHALL keep oe_n and every we_n bit from being low in the same cycle, and keep any strobe from being low while cs_n=1.
REQ-035 SHALL register all bus outputs (glitch-free); none SHALL be decoded combinationally from the state.

Reset
REQ-036 SHALL, with rst high at a clock edge, force IDLE, set the counter to 0, and drive cs_n=1, oe_n=1, we_n=4'b1111, rd_wr=1, data_oe=0, ebi_addr=0, data_o=0, rdata=0, ack=0 and busy=0.
REQ-037 SHALL, on rst asserted mid-transaction, abandon the transaction with no ack and no rdata update, and be ready for a new req on the first cycle after rst falls.

Verification
REQ-038 SHALL cover a default-parameter write: addr=6'h05, wdata=32'hDEADBEEF, be=4'hF -> ebi_addr=8'h14, rd_wr=0, we_n=0000 for 2 cycles, ack 5 cycles after req.
REQ-039 SHALL cover a read: data_i=32'h12345678, addr=6'h3F -> ebi_addr=8'hFC, oe_n low 2 cycles, we_n stays 1111, rdata=32'h12345678 when ack=1.
REQ-040 SHALL cover a partial write with be=4'b0101 -> we_n=4'b1010 during STROBE only.
REQ-041 SHALL cover back-to-back write then read with req held high -> exactly one cs_n=1 cycle between them, with two ack pulses 5 cycles apart.
REQ-042 SHALL cover rst pulsed during STROBE of a write -> next cycle all bus outputs idle, no ack, and a following read completes normally.
REQ-043 SHALL cover T_SETUP=15, T_STROBE=15, T_HOLD=15 -> req-to-ack latency of 46 cycles, strobe low for exactly 15 cycles.

Source files
------------

// File: rtl/ebi_master.sv
// ebi_master: single-transaction external bus interface master.
// A host request is latched in IDLE and played out on the bus as a
// SETUP / STROBE / HOLD sequence whose lengths are set by parameters.
// Every bus-facing output is a flop, so nothing glitches on state changes.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus parked (cs_n=1, strobes high); accepts req; ack pulse here
// SETUP  | cs_n low, direction and data driven, strobes still high
// STROBE | oe_n low (read) or we_n=~be (write); read data sampled at end
// HOLD   | strobes released, cs_n/address/data/direction held steady
module ebi_master #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_STROBE = 2,
  parameter int unsigned T_HOLD   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        cs_n,
  output logic        oe_n,
  output logic [3:0]  we_n,
  output logic        rd_wr,
  output logic [7:0]  ebi_addr,
  output logic [31:0] data_o,
  output logic        data_oe,
  input  logic [31:0] data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The shared counter is loaded with (length - 1) on entry and the state
  // advances when it reaches zero, so each phase lasts exactly its length.
  localparam logic [3:0] SETUP_LD  = 4'(T_SETUP - 1);
  localparam logic [3:0] STROBE_LD = 4'(T_STROBE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(T_HOLD - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       wr_l;
  logic [3:0] be_l;

  // Sequencer: state, shared down-counter and all registered outputs.
  // ebi_addr and data_o double as the latched address and write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wr_l     <= 1'b0;
      be_l     <= 4'd0;
      cs_n     <= 1'b1;
      oe_n     <= 1'b1;
      we_n     <= 4'hF;
      rd_wr    <= 1'b1;
      data_oe  <= 1'b0;
      ebi_addr <= 8'd0;
      data_o   <= 32'd0;
      rdata    <= 32'd0;
      ack      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_l     <= wr;
            be_l     <= be;
            ebi_addr <= {addr, 2'b00};
            data_o   <= wdata;
            cs_n     <= 1'b0;
            rd_wr    <= ~wr;
            data_oe  <= wr;
            busy     <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            // Only one strobe type is ever asserted; be=0 writes keep we_n high.
            if (wr_l) begin
              we_n <= ~be_l;
            end else begin
              oe_n <= 1'b0;
            end
            cnt   <= STROBE_LD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            if (!wr_l) begin
              rdata <= data_i;
            end
            oe_n  <= 1'b1;
            we_n  <= 4'hF;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            cs_n    <= 1'b1;
            rd_wr   <= 1'b1;
            data_oe <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebi_master.sv
// Bench for ebi_master: one default-timing instance (channel 0) and one
// with all phases at 15 cycles (channel 1). Stimulus pushes expected
// transaction results; a negedge monitor measures bus activity and
// compares against the queue on every ack pulse.
module tb_ebi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req      [2];
  logic        wr;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] data_i;
  logic [31:0] rdata    [2];
  logic        ack      [2];
  logic        busy     [2];
  logic        cs_n     [2];
  logic        oe_n     [2];
  logic [3:0]  we_n     [2];
  logic        rd_wr    [2];
  logic [7:0]  ebi_addr [2];
  logic [31:0] data_o   [2];
  logic        data_oe  [2];

  ebi_master dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .cs_n(cs_n[0]),
    .oe_n(oe_n[0]), .we_n(we_n[0]), .rd_wr(rd_wr[0]), .ebi_addr(ebi_addr[0]),
    .data_o(data_o[0]), .data_oe(data_oe[0]), .data_i(data_i)
  );

  ebi_master #(.T_SETUP(15), .T_STROBE(15), .T_HOLD(15)) dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .cs_n(cs_n[1]),
    .oe_n(oe_n[1]), .we_n(we_n[1]), .rd_wr(rd_wr[1]), .ebi_addr(ebi_addr[1]),
    .data_o(data_o[1]), .data_oe(data_oe[1]), .data_i(data_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          req_cyc;
    int          lat;
    int          cs_cnt;
    int          oe_cnt;
    int          we_cnt;
    logic [3:0]  we_pat;
    logic        rd;
    logic [7:0]  eaddr;
    logic [31:0] rdat;
    logic [31:0] wdat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  int          cs_cnt_m [2];
  int          oe_cnt_m [2];
  int          we_cnt_m [2];
  logic [3:0]  we_pat_m [2];
  logic [7:0]  addr_m   [2];
  logic        rdwr_m   [2];
  logic        doe_m    [2];
  logic [31:0] do_m     [2];
  logic        prev_cs  [2] = '{1'b1, 1'b1};
  int          ack_cnt  [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_step(input int ch);
    exp_t e;
    if (!cs_n[ch]) begin
      if (prev_cs[ch]) begin
        cs_cnt_m[ch] = 0;
        oe_cnt_m[ch] = 0;
        we_cnt_m[ch] = 0;
        we_pat_m[ch] = 4'hF;
        addr_m[ch]   = ebi_addr[ch];
        rdwr_m[ch]   = rd_wr[ch];
        doe_m[ch]    = data_oe[ch];
        do_m[ch]     = data_o[ch];
      end else if (ebi_addr[ch] !== addr_m[ch] || rd_wr[ch] !== rdwr_m[ch] ||
                   data_oe[ch] !== doe_m[ch] || data_o[ch] !== do_m[ch]) begin
        viol++;
      end
      cs_cnt_m[ch]++;
      if (!oe_n[ch]) oe_cnt_m[ch]++;
      if (we_n[ch] != 4'hF) begin
        if (we_cnt_m[ch] != 0 && we_n[ch] !== we_pat_m[ch]) viol++;
        we_cnt_m[ch]++;
        we_pat_m[ch] = we_n[ch];
      end
    end
    if (!oe_n[ch] && we_n[ch] != 4'hF) viol++;
    if (cs_n[ch] && (!oe_n[ch] || we_n[ch] != 4'hF)) viol++;
    prev_cs[ch] = cs_n[ch];
    if (ack[ch]) begin
      ack_cnt[ch]++;
      if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
        tests++;
        fails++;
        $display("FAIL ch%0d unexpected_ack: got ack at cycle %0d expected none", ch, cyc);
      end else begin
        e = (ch == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("ch%0d latency", ch), 32'(cyc - e.req_cyc), 32'(e.lat));
        check($sformatf("ch%0d cs_low_cycles", ch), 32'(cs_cnt_m[ch]), 32'(e.cs_cnt));
        check($sformatf("ch%0d oe_low_cycles", ch), 32'(oe_cnt_m[ch]), 32'(e.oe_cnt));
        check($sformatf("ch%0d we_low_cycles", ch), 32'(we_cnt_m[ch]), 32'(e.we_cnt));
        check($sformatf("ch%0d we_pattern", ch), 32'(we_pat_m[ch]), 32'(e.we_pat));
        check($sformatf("ch%0d rd_wr", ch), 32'(rdwr_m[ch]), 32'(e.rd));
        check($sformatf("ch%0d data_oe", ch), 32'(doe_m[ch]), 32'(!e.rd));
        check($sformatf("ch%0d ebi_addr", ch), 32'(addr_m[ch]), 32'(e.eaddr));
        check($sformatf("ch%0d busy_at_ack", ch), 32'(busy[ch]), 32'd0);
        if (e.rd) check($sformatf("ch%0d rdata", ch), rdata[ch], e.rdat);
        else      check($sformatf("ch%0d data_o", ch), do_m[ch], e.wdat);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  // Caller is in the low clock phase. Drives req for one sampling edge
  // (or leaves it high when hold is set) and returns at the next negedge.
  task automatic issue(input int ch, input logic w, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [7:0] ex_addr, input logic [3:0] ex_we,
                       input logic [31:0] ex_rd, input int lat, input int tst,
                       input logic push, input logic hold);
    exp_t e;
    wr = w; addr = a; wdata = d; be = b;
    req[ch] = 1'b1;
    e.req_cyc = cyc;
    e.lat     = lat;
    e.cs_cnt  = lat - 1;
    e.oe_cnt  = w ? 0 : tst;
    e.we_cnt  = (ex_we != 4'hF) ? tst : 0;
    e.we_pat  = ex_we;
    e.rd      = !w;
    e.eaddr   = ex_addr;
    e.rdat    = ex_rd;
    e.wdat    = d;
    if (push) begin
      if (ch == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    if (!hold) req[ch] = 1'b0;
  endtask

  task automatic wait_ack(input int ch, input int target, input int budget);
    int n;
    n = 0;
    while (ack_cnt[ch] < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (ack_cnt[ch] < target) begin
      tests++;
      fails++;
      $display("FAIL ch%0d ack_timeout: got %0d acks expected %0d", ch, ack_cnt[ch], target);
    end
  endtask

  task automatic check_idle(input int ch, input string tag);
    check($sformatf("%s ch%0d cs_n", tag, ch),     32'(cs_n[ch]), 32'd1);
    check($sformatf("%s ch%0d oe_n", tag, ch),     32'(oe_n[ch]), 32'd1);
    check($sformatf("%s ch%0d we_n", tag, ch),     32'(we_n[ch]), 32'hF);
    check($sformatf("%s ch%0d rd_wr", tag, ch),    32'(rd_wr[ch]), 32'd1);
    check($sformatf("%s ch%0d data_oe", tag, ch),  32'(data_oe[ch]), 32'd0);
    check($sformatf("%s ch%0d ebi_addr", tag, ch), 32'(ebi_addr[ch]), 32'd0);
    check($sformatf("%s ch%0d data_o", tag, ch),   data_o[ch], 32'd0);
    check($sformatf("%s ch%0d rdata", tag, ch),    rdata[ch], 32'd0);
    check($sformatf("%s ch%0d ack", tag, ch),      32'(ack[ch]), 32'd0);
    check($sformatf("%s ch%0d busy", tag, ch),     32'(busy[ch]), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    wr = 1'b0; addr = 6'd0; wdata = 32'd0; be = 4'd0; data_i = 32'd0;
    repeat (3) @(negedge clk);
    check_idle(0, "reset");
    check_idle(1, "reset");
    rst = 1'b0;
    @(negedge clk);

    // Full write, full read, partial write, zero-byte-enable write.
    issue(0, 1'b1, 6'h05, 32'hDEADBEEF, 4'hF, 8'h14, 4'h0, 32'h0, 5, 2, 1'b1, 1'b0);
    wait_ack(0, 1, 20);
    data_i = 32'h12345678;
    issue(0, 1'b0, 6'h3F, 32'h0, 4'hF, 8'hFC, 4'hF, 32'h12345678, 5, 2, 1'b1, 1'b0);
    wait_ack(0, 2, 20);
    issue(0, 1'b1, 6'h0A, 32'hA5A50F0F, 4'b0101, 8'h28, 4'b1010, 32'h0, 5, 2, 1'b1, 1'b0);
    wait_ack(0, 3, 20);
    issue(0, 1'b1, 6'h01, 32'h01020304, 4'b0000, 8'h04, 4'hF, 32'h0, 5, 2, 1'b1, 1'b0);
    wait_ack(0, 4, 20);
    check("rdata_kept_over_writes", rdata[0], 32'h12345678);

    // Back-to-back: req stays high, second request is taken in the ack cycle.
    k = cyc;
    issue(0, 1'b1, 6'h10, 32'h0BADCAFE, 4'b1100, 8'h40, 4'b0011, 32'h0, 5, 2, 1'b1, 1'b1);
    wr = 1'b0; addr = 6'h22; data_i = 32'hCAFEF00D;
    begin
      exp_t e;
      e.req_cyc = k + 5; e.lat = 5; e.cs_cnt = 4; e.oe_cnt = 2; e.we_cnt = 0;
      e.we_pat = 4'hF; e.rd = 1'b1; e.eaddr = 8'h88; e.rdat = 32'hCAFEF00D; e.wdat = 32'h0;
      q0.push_back(e);
    end
    repeat (5) @(negedge clk);
    req[0] = 1'b0;
    wait_ack(0, 6, 20);

    // Reset in the middle of a write strobe.
    data_i = 32'h5555AAAA;
    issue(0, 1'b1, 6'h07, 32'h11112222, 4'hF, 8'h1C, 4'h0, 32'h0, 5, 2, 1'b0, 1'b0);
    @(negedge clk);
    check("strobe_before_reset", 32'(we_n[0]), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "midreset");
    issue(0, 1'b0, 6'h2C, 32'h0, 4'hF, 8'hB0, 4'hF, 32'h5555AAAA, 5, 2, 1'b1, 1'b0);
    wait_ack(0, 7, 20);
    check("ack_count_after_reset", 32'(ack_cnt[0]), 32'd7);

    // Maximum phase lengths.
    issue(1, 1'b1, 6'h05, 32'hDEADBEEF, 4'hF, 8'h14, 4'h0, 32'h0, 46, 15, 1'b1, 1'b0);
    wait_ack(1, 1, 80);
    data_i = 32'h12345678;
    issue(1, 1'b0, 6'h3F, 32'h0, 4'hF, 8'hFC, 4'hF, 32'h12345678, 46, 15, 1'b1, 1'b0);
    wait_ack(1, 2, 80);

    repeat (3) @(negedge clk);
    check("bus_rule_violations", 32'(viol), 32'd0);
    check("ch0_pending", 32'(q0.size()), 32'd0);
    check("ch1_pending", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
